// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM states, buffer depth and segment table for the scroll sequencer
package seg_pkg;

  localparam int unsigned DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Indexed by hex value; bit0 = segment a, bit6 = segment g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational hex nibble to seven-segment decode
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scroll_sequencer.sv
// rtl/seg_scroll_sequencer.sv - loads hex nibbles into a small buffer and scrolls them on a 7-seg display
module seg_scroll_sequencer
  import seg_pkg::*;
#(
  parameter int unsigned MAX_COUNT   = 1000,
  parameter int unsigned BLANK_COUNT = 100,
  parameter int unsigned DEPTH       = seg_pkg::DEPTH
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned CNT_MAX = (MAX_COUNT > BLANK_COUNT) ? MAX_COUNT : BLANK_COUNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned LEN_W   = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;
  assign clk   = io_in[0];
  assign rst_n = io_in[1];

  // {data[3:0], run, wr} synchronized as one bundle so data lines up with its strobe
  logic [5:0] meta_q;
  logic [5:0] sync_q;
  logic       wr_prev_q;
  logic       sync_wr;
  logic       sync_run;
  logic [3:0] sync_data;
  logic       wr_edge;

  assign sync_wr   = sync_q[0];
  assign sync_run  = sync_q[1];
  assign sync_data = sync_q[5:2];
  assign wr_edge   = sync_wr & ~wr_prev_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]         io_out_q, io_out_d;
  logic               buf_we;
  logic [3:0]         buf_q [DEPTH];
  logic [6:0]         seg;
  logic               rd_last;

  assign rd_last = (rd_idx_q == IDX_W'(len_q - LEN_W'(1)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    buf_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_edge) begin
          if (sync_run) begin
            len_d    = '0;
            wr_ptr_d = '0;
          end else if (len_q != LEN_W'(DEPTH)) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + LEN_W'(1);
            len_d    = len_q + LEN_W'(1);
          end
        end else if (sync_run && (len_q != '0)) begin
          state_d  = ST_SHOW;
          rd_idx_d = '0;
          cnt_d    = '0;
        end
      end
      ST_SHOW: begin
        if (!sync_run) begin
          state_d  = ST_IDLE;
          rd_idx_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(MAX_COUNT - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (!sync_run) begin
          state_d  = ST_IDLE;
          rd_idx_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(BLANK_COUNT - 1)) begin
          state_d  = ST_SHOW;
          cnt_d    = '0;
          rd_idx_d = rd_last ? '0 : rd_idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output is decoded from next-state values so the register lines up with the FSM
  seg_hex_decoder u_dec (
    .hex_i (buf_q[rd_idx_d]),
    .seg_o (seg)
  );

  always_comb begin
    io_out_d = 8'h00;
    if (state_d == ST_SHOW) begin
      io_out_d = {(rd_idx_d == '0), seg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      wr_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_idx_q  <= '0;
      len_q     <= '0;
      wr_ptr_q  <= '0;
      io_out_q  <= 8'h00;
    end else begin
      meta_q    <= io_in[7:2];
      sync_q    <= meta_q;
      wr_prev_q <= sync_wr;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_idx_q  <= rd_idx_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      io_out_q  <= io_out_d;
    end
  end

  // Contents are masked by len, so the storage itself carries no reset
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_ptr_q[IDX_W-1:0]] <= sync_data;
    end
  end

  assign io_out = io_out_q;

endmodule
